// File: rtl/stream_demux1_2.sv
// 1-to-2 valid/ready stream demultiplexer: in_sel routes each word into channel A or B FIFO.
// Optional DEMUX_COUNT_EN adds 16-bit per-channel delivered-word counters (a_count/b_count).

module stream_demux1_2_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_full
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nxt;
    logic             r_valid;
    logic             r_full;
    logic             w_do_push;
    logic             w_do_pop;
    logic [WIDTH-1:0] r_mem [DEPTH];

    assign w_do_push = i_push & ~r_full;
    assign w_do_pop  = i_pop & r_valid;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Flags are registered from the next occupancy so in_ready never sees a_ready/b_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_full   <= 1'b0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != '0);
            r_full  <= (w_count_nxt == FULL_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_valid ? r_mem[r_rd_ptr] : '0;
    assign o_valid = r_valid;
    assign o_full  = r_full;
endmodule

module stream_demux1_2 #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready
`ifdef DEMUX_COUNT_EN
    ,
    output logic [15:0]      a_count,
    output logic [15:0]      b_count
`endif
);
    logic w_full_a;
    logic w_full_b;
    logic w_push_a;
    logic w_push_b;
    logic w_pop_a;
    logic w_pop_b;

    assign in_ready = in_sel ? ~w_full_b : ~w_full_a;
    assign w_push_a = in_valid & in_ready & ~in_sel;
    assign w_push_b = in_valid & in_ready & in_sel;
    assign w_pop_a  = a_valid & a_ready;
    assign w_pop_b  = b_valid & b_ready;

    stream_demux1_2_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push_a),
        .i_data  (in_data),
        .i_pop   (a_ready),
        .o_data  (a_data),
        .o_valid (a_valid),
        .o_full  (w_full_a)
    );

    stream_demux1_2_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push_b),
        .i_data  (in_data),
        .i_pop   (b_ready),
        .o_data  (b_data),
        .o_valid (b_valid),
        .o_full  (w_full_b)
    );

`ifdef DEMUX_COUNT_EN
    logic [15:0] r_a_count;
    logic [15:0] r_b_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_count <= '0;
            r_b_count <= '0;
        end else begin
            if (w_pop_a) r_a_count <= r_a_count + 16'd1;
            if (w_pop_b) r_b_count <= r_b_count + 16'd1;
        end
    end

    assign a_count = r_a_count;
    assign b_count = r_b_count;
`else
    logic w_unused_pops;
    assign w_unused_pops = w_pop_a ^ w_pop_b;
`endif
endmodule
